// File: rtl/mips_mc_ctrl_p.sv
// Multicycle MIPS control unit with MEM_W-wide multi-beat instruction fetch,
// memory-ready stalls and illegal-opcode trap reporting.
module mips_mc_ctrl_p #(
  parameter int unsigned MEM_W = 8,
  localparam int unsigned FETCH_BEATS = 32 / MEM_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   fetch_en,
  input  logic [31:0]            instr,
  input  logic                   mem_ready_i,
  output logic                   IorD,
  output logic                   MemWrite,
  output logic [FETCH_BEATS-1:0] IRWrite,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ALUOp,
  output logic [1:0]             PCSrc,
  output logic                   Branch,
  output logic                   PCWrite,
  output logic                   RegDst,
  output logic                   MemtoReg,
  output logic                   trap_o,
  output logic [3:0]             state_o
);

  if (!(MEM_W == 8 || MEM_W == 16 || MEM_W == 32)) begin : gen_bad_mem_w
    $error("mips_mc_ctrl_p: MEM_W must be 8, 16 or 32");
  end

  localparam int unsigned BeatW = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(FETCH_BEATS - 1);

  localparam logic [5:0] OpR    = 6'h00;
  localparam logic [5:0] OpLw   = 6'h23;
  localparam logic [5:0] OpSw   = 6'h2B;
  localparam logic [5:0] OpBeq  = 6'h04;
  localparam logic [5:0] OpAddi = 6'h08;
  localparam logic [5:0] OpJ    = 6'h02;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11,
    StTrap   = 4'd12
  } state_e;

  state_e           state_q, state_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [5:0]       opcode;
  logic             unused_instr;

  assign opcode       = instr[31:26];
  assign unused_instr = ^instr[25:0];
  assign state_o      = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StFetch;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = '0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
    Branch   = 1'b0;
    PCWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    trap_o   = 1'b0;

    unique case (state_q)
      StFetch: begin
        ALUSrcB = 2'b01;
        // fetch_en only gates the start of a fetch; a started fetch always completes
        if ((beat_q != '0 || fetch_en) && mem_ready_i) begin
          IRWrite = FETCH_BEATS'(1) << beat_q;
          PCWrite = 1'b1;
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            state_d = StDecode;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      StDecode: begin
        ALUSrcB = 2'b11;
        unique case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        IorD = 1'b1;
        if (mem_ready_i) state_d = StMemWb;
      end
      StMemWb: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StMemWr: begin
        IorD     = 1'b1;
        MemWrite = mem_ready_i;
        if (mem_ready_i) state_d = StFetch;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = StAluWb;
      end
      StAluWb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
        state_d = StFetch;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StJump: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        state_d = StFetch;
      end
      StTrap: begin
        trap_o  = 1'b1;
        state_d = StFetch;
      end
      default: begin
        state_d = StFetch;
        beat_d  = '0;
      end
    endcase

    // Reset holds every strobe and select low, even while FETCH would otherwise fire.
    if (rst_i) begin
      IorD     = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = '0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUOp    = 2'b00;
      PCSrc    = 2'b00;
      Branch   = 1'b0;
      PCWrite  = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      trap_o   = 1'b0;
    end
  end

endmodule
